// File: rtl/half_duplex_bram_arbiter.sv
// Half-duplex arbiter sharing one BRAM port between a block-read path (into an FWFT read buffer)
// and a block-write path (drained from a write buffer). One direction is active at a time.
module half_duplex_bram_arbiter #(
    parameter int unsigned BUF_DEPTH  = 256,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        advanceBuffer,
    input  logic        clear,
    input  logic [15:0] requestAddr_read,
    input  logic [15:0] numReads,
    output logic [31:0] requestData,
    output logic        dataValid,
    input  logic [31:0] readData,
    input  logic        resetBusy,
    output logic [14:0] addr,
    output logic [31:0] writeData,
    output logic        bramEnable,
    output logic        bramWe,
    input  logic [15:0] requestAddr_write,
    input  logic [8:0]  numWrites,
    input  logic [31:0] sendData,
    input  logic        pulseWrite,
    input  logic        readReq,
    input  logic        writeReq,
    output logic [8:0]  wr_data_count
);

    localparam int unsigned AW = $clog2(BUF_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [2:0] {
        StIdle, StRdIssue, StRdWait, StRdCapture, StWrDrain, StDone
    } stateT;

    stateT stateQ, stateD;
    logic [15:0] baseQ, baseD, countQ, countD, offsetQ, offsetD;
    logic [LW-1:0] waitQ, waitD;
    logic dirReadQ, dirReadD;
    logic readArmedQ, readArmedD, writeArmedQ, writeArmedD;
    logic pulseWriteQ;
    logic [14:0] addrHoldQ;
    logic [31:0] wdHoldQ;

    logic [31:0] rdMem [BUF_DEPTH];
    logic [AW-1:0] rdWrPtrQ, rdRdPtrQ;
    logic [CW-1:0] rdCountQ;
    logic rdPush, rdPop, rdFull;

    logic [31:0] wrMem [BUF_DEPTH];
    logic [AW-1:0] wrWrPtrQ, wrRdPtrQ;
    logic [CW-1:0] wrCountQ;
    logic wrPush, wrPop, wrFull;
    logic [31:0] wrHead;

    logic [15:0] addrSum, wrAvail, wrAsked, wrMin;
    logic unusedAddrMsb;

    assign addrSum       = baseQ + offsetQ;
    assign unusedAddrMsb = addrSum[15];
    assign wrAvail       = 16'(wrCountQ);
    assign wrAsked       = 16'(numWrites);
    assign wrMin         = (wrAsked < wrAvail) ? wrAsked : wrAvail;

    // Power-of-two depth: full exactly when the count MSB is set.
    assign rdFull = rdCountQ[AW];
    assign wrFull = wrCountQ[AW];
    assign rdPop  = advanceBuffer && (rdCountQ != '0);
    // Accept a push while full only when a pop frees a slot in the same cycle.
    assign wrPush = pulseWrite && !pulseWriteQ && (!wrFull || wrPop);
    assign wrHead = wrMem[wrRdPtrQ];

    assign requestData   = (rdCountQ == '0) ? 32'd0 : rdMem[rdRdPtrQ];
    assign dataValid     = (stateQ == StDone);
    assign addr          = bramEnable ? addrSum[14:0] : addrHoldQ;
    assign writeData     = bramWe ? wrHead : wdHoldQ;
    assign wr_data_count = 9'(wrCountQ);

    always_comb begin
        stateD      = stateQ;
        baseD       = baseQ;
        countD      = countQ;
        offsetD     = offsetQ;
        waitD       = waitQ;
        dirReadD    = dirReadQ;
        readArmedD  = readArmedQ;
        writeArmedD = writeArmedQ;
        bramEnable  = 1'b0;
        bramWe      = 1'b0;
        rdPush      = 1'b0;
        wrPop       = 1'b0;
        case (stateQ)
            StIdle: begin
                if (!resetBusy) begin
                    if (readReq && readArmedQ) begin
                        baseD    = requestAddr_read;
                        countD   = numReads;
                        offsetD  = 16'd0;
                        dirReadD = 1'b1;
                        stateD   = (numReads == 16'd0) ? StDone : StRdIssue;
                    end else if (writeReq && writeArmedQ) begin
                        baseD    = requestAddr_write;
                        countD   = wrMin;
                        offsetD  = 16'd0;
                        dirReadD = 1'b0;
                        stateD   = (wrMin == 16'd0) ? StDone : StWrDrain;
                    end
                end
            end
            StRdIssue: begin
                if (!rdFull && !resetBusy) begin
                    bramEnable = 1'b1;
                    waitD      = '0;
                    stateD     = StRdWait;
                end
            end
            StRdWait: begin
                if (waitQ == LW'(RD_LATENCY - 1)) begin
                    stateD = StRdCapture;
                end else begin
                    waitD = waitQ + LW'(1);
                end
            end
            StRdCapture: begin
                rdPush  = 1'b1;
                offsetD = offsetQ + 16'd1;
                stateD  = (offsetQ + 16'd1 == countQ) ? StDone : StRdIssue;
            end
            StWrDrain: begin
                bramEnable = 1'b1;
                bramWe     = 1'b1;
                wrPop      = 1'b1;
                offsetD    = offsetQ + 16'd1;
                if (offsetQ + 16'd1 == countQ) begin
                    stateD = StDone;
                end
            end
            StDone: begin
                stateD = StIdle;
            end
            default: stateD = StIdle;
        endcase
        if (stateQ == StDone) begin
            if (dirReadQ) begin
                readArmedD = 1'b0;
            end else begin
                writeArmedD = 1'b0;
            end
        end
        // A request must be seen low before the same direction can start again.
        if (!readReq) begin
            readArmedD = 1'b1;
        end
        if (!writeReq) begin
            writeArmedD = 1'b1;
        end
        if (!clear) begin
            stateD = StIdle;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            stateQ      <= StIdle;
            baseQ       <= 16'd0;
            countQ      <= 16'd0;
            offsetQ     <= 16'd0;
            waitQ       <= '0;
            dirReadQ    <= 1'b0;
            readArmedQ  <= 1'b1;
            writeArmedQ <= 1'b1;
            pulseWriteQ <= 1'b0;
            addrHoldQ   <= 15'd0;
            wdHoldQ     <= 32'd0;
        end else begin
            stateQ      <= stateD;
            baseQ       <= baseD;
            countQ      <= countD;
            offsetQ     <= offsetD;
            waitQ       <= waitD;
            dirReadQ    <= dirReadD;
            readArmedQ  <= readArmedD;
            writeArmedQ <= writeArmedD;
            pulseWriteQ <= pulseWrite;
            if (bramEnable) begin
                addrHoldQ <= addrSum[14:0];
            end
            if (bramWe) begin
                wdHoldQ <= wrHead;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdPush) begin
            rdMem[rdWrPtrQ] <= readData;
        end
        if (wrPush) begin
            wrMem[wrWrPtrQ] <= sendData;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rdWrPtrQ <= '0;
            rdRdPtrQ <= '0;
            rdCountQ <= '0;
            wrWrPtrQ <= '0;
            wrRdPtrQ <= '0;
            wrCountQ <= '0;
        end else if (!clear) begin
            rdWrPtrQ <= '0;
            rdRdPtrQ <= '0;
            rdCountQ <= '0;
            wrWrPtrQ <= '0;
            wrRdPtrQ <= '0;
            wrCountQ <= '0;
        end else begin
            if (rdPush) begin
                rdWrPtrQ <= rdWrPtrQ + AW'(1);
            end
            if (rdPop) begin
                rdRdPtrQ <= rdRdPtrQ + AW'(1);
            end
            rdCountQ <= rdCountQ + CW'(rdPush) - CW'(rdPop);
            if (wrPush) begin
                wrWrPtrQ <= wrWrPtrQ + AW'(1);
            end
            if (wrPop) begin
                wrRdPtrQ <= wrRdPtrQ + AW'(1);
            end
            wrCountQ <= wrCountQ + CW'(wrPush) - CW'(wrPop);
        end
    end

endmodule

// File: tb/tb_half_duplex_bram_arbiter.sv
// Directed + randomized bench for half_duplex_bram_arbiter with a BRAM model and a
// queue/array reference of memory contents and write-buffer contents.
module tb_half_duplex_bram_arbiter;

    logic        clk;
    logic        resetN;
    logic        advanceBuffer;
    logic        clear;
    logic [15:0] requestAddr_read;
    logic [15:0] numReads;
    logic [31:0] requestData;
    logic        dataValid;
    logic [31:0] readData = 32'd0;
    logic        resetBusy;
    logic [14:0] addr;
    logic [31:0] writeData;
    logic        bramEnable;
    logic        bramWe;
    logic [15:0] requestAddr_write;
    logic [8:0]  numWrites;
    logic [31:0] sendData;
    logic        pulseWrite;
    logic        readReq;
    logic        writeReq;
    logic [8:0]  wr_data_count;

    half_duplex_bram_arbiter #(
        .BUF_DEPTH (256),
        .RD_LATENCY(2)
    ) dut (
        .clk              (clk),
        .resetN           (resetN),
        .advanceBuffer    (advanceBuffer),
        .clear            (clear),
        .requestAddr_read (requestAddr_read),
        .numReads         (numReads),
        .requestData      (requestData),
        .dataValid        (dataValid),
        .readData         (readData),
        .resetBusy        (resetBusy),
        .addr             (addr),
        .writeData        (writeData),
        .bramEnable       (bramEnable),
        .bramWe           (bramWe),
        .requestAddr_write(requestAddr_write),
        .numWrites        (numWrites),
        .sendData         (sendData),
        .pulseWrite       (pulseWrite),
        .readReq          (readReq),
        .writeReq         (writeReq),
        .wr_data_count    (wr_data_count)
    );

    typedef struct {
        logic [14:0] a;
        logic        we;
        logic [31:0] d;
        int          cyc;
    } accT;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int dvCount = 0;
    accT accQ[$];
    logic [31:0] wrModel[$];
    logic [31:0] refMem [32768];
    int unsigned memSeed;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] initWord(input int a, input int unsigned seed);
        case (a)
            0:       return 32'h6F3B2A1C;
            1:       return 32'h12345678;
            7:       return 32'h0F0F0F0F;
            default: return (32'(a) * 32'h9E3779B9) ^ seed;
        endcase
    endfunction

    // BRAM model: data valid two cycles after the enable edge, held until the next read.
    logic [31:0] bramMem [32768];
    logic        loaded = 1'b0;
    logic        p1v = 1'b0;
    logic [31:0] p1d = 32'd0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 32768; i++) bramMem[i] <= initWord(i, memSeed);
            loaded <= 1'b1;
        end else if (bramEnable && bramWe) begin
            bramMem[addr] <= writeData;
        end
        p1v <= bramEnable && !bramWe;
        p1d <= bramMem[addr];
        if (p1v) readData <= p1d;
    end

    always @(negedge clk) begin
        if (resetN) begin
            if (bramEnable) accQ.push_back('{addr, bramWe, writeData, cyc});
            if (dataValid) dvCount <= dvCount + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitDv(input int target, input int budget, input string tag);
        int n = 0;
        while (dvCount < target && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, 32'(dvCount), 32'(target));
    endtask

    task automatic pushWord(input logic [31:0] w);
        sendData   = w;
        pulseWrite = 1'b1;
        tick(2);
        pulseWrite = 1'b0;
        tick(1);
        if (wrModel.size() < 256) wrModel.push_back(w);
    endtask

    function automatic logic [31:0] wrapAddr(input int base, input int i);
        return 32'((base + i) & 32'h7FFF);
    endfunction

    task automatic runRead(input int base, input int n, input string tag, input bit hold);
        int s = accQ.size();
        int dv0 = dvCount;
        requestAddr_read = 16'(base);
        numReads         = 16'(n);
        readReq          = 1'b1;
        waitDv(dv0 + 1, 8 * n + 20, {tag, " done"});
        tick(3);
        if (!hold) readReq = 1'b0;
        check({tag, " dv once"}, 32'(dvCount), 32'(dv0 + 1));
        check({tag, " nacc"}, 32'(accQ.size() - s), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (s + i < accQ.size()) begin
                check($sformatf("%s addr%0d", tag, i), 32'(accQ[s+i].a), wrapAddr(base, i));
                check($sformatf("%s we%0d", tag, i), 32'(accQ[s+i].we), 32'd0);
                if (i > 0)
                    check($sformatf("%s gap%0d", tag, i),
                          32'(accQ[s+i].cyc - accQ[s+i-1].cyc), 32'd4);
            end
        end
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s data%0d", tag, i), requestData,
                  refMem[wrapAddr(base, i)]);
            advanceBuffer = 1'b1;
            tick(1);
            advanceBuffer = 1'b0;
        end
        check({tag, " empty"}, requestData, 32'd0);
    endtask

    task automatic runWrite(input int base, input int nw, input string tag);
        int s = accQ.size();
        int dv0 = dvCount;
        int k = (nw < wrModel.size()) ? nw : wrModel.size();
        logic [31:0] exp;
        requestAddr_write = 16'(base);
        numWrites         = 9'(nw);
        writeReq          = 1'b1;
        waitDv(dv0 + 1, k + 20, {tag, " done"});
        tick(3);
        writeReq = 1'b0;
        check({tag, " dv once"}, 32'(dvCount), 32'(dv0 + 1));
        check({tag, " nacc"}, 32'(accQ.size() - s), 32'(k));
        for (int i = 0; i < k; i++) begin
            exp = wrModel.pop_front();
            refMem[wrapAddr(base, i)] = exp;
            if (s + i < accQ.size()) begin
                check($sformatf("%s addr%0d", tag, i), 32'(accQ[s+i].a), wrapAddr(base, i));
                check($sformatf("%s we%0d", tag, i), 32'(accQ[s+i].we), 32'd1);
                check($sformatf("%s wd%0d", tag, i), accQ[s+i].d, exp);
                check($sformatf("%s cyc%0d", tag, i), 32'(accQ[s+i].cyc - accQ[s].cyc),
                      32'(i));
            end
        end
        tick(1);
        check({tag, " count"}, 32'(wr_data_count), 32'(wrModel.size()));
    endtask

    initial begin
        int s;
        int dv0;
        int rb;
        int wb;
        memSeed = $urandom;
        for (int i = 0; i < 32768; i++) refMem[i] = initWord(i, memSeed);
        resetN = 1'b0; advanceBuffer = 1'b0; clear = 1'b1; requestAddr_read = 16'd0;
        numReads = 16'd0; resetBusy = 1'b0; requestAddr_write = 16'd0; numWrites = 9'd0;
        sendData = 32'd0; pulseWrite = 1'b0; readReq = 1'b0; writeReq = 1'b0;
        tick(3);
        check("rst requestData", requestData, 32'd0);
        check("rst dataValid", 32'(dataValid), 32'd0);
        check("rst bramEnable", 32'(bramEnable), 32'd0);
        check("rst bramWe", 32'(bramWe), 32'd0);
        check("rst addr", 32'(addr), 32'd0);
        check("rst writeData", writeData, 32'd0);
        check("rst wrcount", 32'(wr_data_count), 32'd0);
        resetN = 1'b1;
        tick(2);

        // Eight-word burst from 0, request held high afterwards.
        runRead(0, 8, "rd8", 1'b1);
        s = accQ.size();
        dv0 = dvCount;
        tick(30);
        check("held nacc", 32'(accQ.size() - s), 32'd0);
        check("held dv", 32'(dvCount), 32'(dv0));
        readReq = 1'b0;
        tick(2);
        runRead(7, 5, "rd7", 1'b0);
        tick(2);
        runRead(int'($urandom_range(16'h7FF0, 0)), int'($urandom_range(12, 1)), "rdrnd", 1'b0);
        tick(2);

        // 245 pushes then one 245-word drain.
        for (int i = 0; i < 245; i++) pushWord(32'(2 * i));
        check("fill count", 32'(wr_data_count), 32'd245);
        runWrite(0, 245, "wr245");
        tick(2);

        // numWrites above and below the occupancy.
        for (int i = 0; i < int'($urandom_range(10, 3)); i++) pushWord($urandom);
        runWrite(int'($urandom_range(16'hFFFF, 0)), int'($urandom_range(12, 1)), "wrrnd");
        tick(2);
        runWrite(int'($urandom_range(16'hFFFF, 0)), 255, "wrrest");
        tick(2);

        // Both requests together, held off by resetBusy; read must go first.
        for (int i = 0; i < 3; i++) pushWord($urandom);
        rb = 16'h2000 + int'($urandom_range(255, 0));
        wb = 16'h4000 + int'($urandom_range(255, 0));
        s = accQ.size();
        dv0 = dvCount;
        resetBusy = 1'b1;
        requestAddr_read = 16'(rb); numReads = 16'd3;
        requestAddr_write = 16'(wb); numWrites = 9'd3;
        readReq = 1'b1; writeReq = 1'b1;
        tick(20);
        check("busy nacc", 32'(accQ.size() - s), 32'd0);
        resetBusy = 1'b0;
        waitDv(dv0 + 2, 100, "both done");
        tick(3);
        readReq = 1'b0; writeReq = 1'b0;
        check("both nacc", 32'(accQ.size() - s), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (s + i < accQ.size()) begin
                check($sformatf("both we%0d", i), 32'(accQ[s+i].we), (i < 3) ? 32'd0 : 32'd1);
                check($sformatf("both addr%0d", i), 32'(accQ[s+i].a),
                      (i < 3) ? wrapAddr(rb, i) : wrapAddr(wb, i - 3));
            end
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("both rdata%0d", i), requestData, refMem[wrapAddr(rb, i)]);
            advanceBuffer = 1'b1;
            tick(1);
            advanceBuffer = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            if (s + 3 + i < accQ.size())
                check($sformatf("both wd%0d", i), accQ[s+3+i].d, wrModel[0]);
            refMem[wrapAddr(wb, i)] = wrModel.pop_front();
        end
        check("both count", 32'(wr_data_count), 32'd0);
        tick(2);

        runRead(16'h7FFE, 4, "wrap", 1'b0);
        tick(2);

        // Flush mid-burst: no completion pulse, no further accesses, both buffers empty.
        pushWord($urandom);
        pushWord($urandom);
        dv0 = dvCount;
        requestAddr_read = 16'($urandom_range(16'h7000, 0));
        numReads = 16'd10;
        readReq = 1'b1;
        tick(9);
        readReq = 1'b0;
        clear = 1'b0;
        tick(1);
        clear = 1'b1;
        wrModel.delete();
        s = accQ.size();
        check("clr requestData", requestData, 32'd0);
        check("clr wrcount", 32'(wr_data_count), 32'd0);
        tick(40);
        check("clr nacc", 32'(accQ.size() - s), 32'd0);
        check("clr dv", 32'(dvCount), 32'(dv0));

        runRead(int'($urandom_range(16'hFFFF, 0)), 0, "rdzero", 1'b0);
        tick(2);
        runWrite(int'($urandom_range(16'hFFFF, 0)), 5, "wrzero");
        tick(2);

        // Asynchronous reset mid-burst.
        pushWord($urandom);
        requestAddr_read = 16'($urandom_range(16'h7000, 0));
        numReads = 16'd6;
        readReq = 1'b1;
        tick(7);
        resetN = 1'b0;
        #1;
        wrModel.delete();
        check("arst bramEnable", 32'(bramEnable), 32'd0);
        check("arst bramWe", 32'(bramWe), 32'd0);
        check("arst dataValid", 32'(dataValid), 32'd0);
        check("arst requestData", requestData, 32'd0);
        check("arst wrcount", 32'(wr_data_count), 32'd0);
        check("arst addr", 32'(addr), 32'd0);
        readReq = 1'b0;
        tick(2);
        resetN = 1'b1;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
